rtr_route_gen: RTL and testbench

//  Per-input-VC route generator: the producing end of the route information that
//  rtr_route_filter checks. Computes output port and output resource class for each

---
 rtl/rtr_route_gen_pkg.sv | 62 ++++++
 rtl/rtr_route_gen_if.sv | 39 +++
 rtl/rtr_dor_next_hop.sv | 38 +++
 rtl/rtr_route_gen.sv | 121 ++++++++++++
 tb/tb_rtr_route_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rtr_route_gen_pkg.sv
// Shared types and constants for the route generator and its next-hop helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rtr_route_gen_pkg;

  // Ceiling log2, never below 1 so a single-entry field still gets a bit.
  function automatic int clogb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int num_dimensions       = 2;
  localparam int num_routers_per_dim  = 4;
  localparam int num_nodes_per_router = 1;
  localparam int num_resource_classes = 2;

  localparam int dim_addr_width    = clogb(num_routers_per_dim);
  localparam int router_addr_width = num_dimensions * dim_addr_width;
  localparam int node_addr_width   = clogb(num_nodes_per_router);
  localparam int num_ports         = 2 * num_dimensions + num_nodes_per_router;
  localparam int rc_idx_width      = clogb(num_resource_classes);

  // Port numbering: dim d -> 2d (coordinate decreasing), 2d+1 (increasing);
  // ejection ports come last.
  localparam int port_dir_dec   = 0;
  localparam int port_dir_inc   = 1;
  localparam int port_eject_base = num_ports - num_nodes_per_router;

  typedef logic [router_addr_width-1:0]    router_addr_t;
  typedef logic [node_addr_width-1:0]      node_addr_t;
  typedef logic [rc_idx_width-1:0]         rc_idx_t;
  typedef logic [num_resource_classes-1:0] rc_oh_t;
  typedef logic [num_ports-1:0]            port_oh_t;

  localparam rc_idx_t rc_last = rc_idx_t'(num_resource_classes - 1);

  // Route carried alongside each flit.
  typedef struct packed {
    port_oh_t op;
    rc_oh_t   orc;
  } route_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } route_gen_state_e;

  // Lowest set bit wins; an all-zero vector maps to class 0.
  function automatic rc_idx_t rc_index(input rc_oh_t rc_oh);
    rc_idx_t idx;
    idx = '0;
    for (int i = num_resource_classes - 1; i >= 0; i--) begin
      if (rc_oh[i]) idx = rc_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rtr_route_gen_if.sv
// Flit-in / route-out handshake bundle of the route generator.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the flit side and the route side.
// Ports: in_* flit offered by the input buffer, out_* route to the allocators.
interface rtr_route_gen_if;
  import rtr_route_gen_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic         in_head;
  logic         in_tail;
  rc_oh_t       in_rc;
  router_addr_t in_dest_router;
  node_addr_t   in_dest_node;
  router_addr_t in_int_router;

  logic         out_valid;
  logic         out_ready;
  logic         out_head;
  logic         out_tail;
  port_oh_t     route_op;
  rc_oh_t       route_orc;
  logic [1:0]   errors;

  // Flit source / route consumer side.
  modport master (
    output in_valid, in_head, in_tail, in_rc, in_dest_router, in_dest_node,
           in_int_router, out_ready,
    input  in_ready, out_valid, out_head, out_tail, route_op, route_orc, errors
  );

  // Route generator side.
  modport slave (
    input  in_valid, in_head, in_tail, in_rc, in_dest_router, in_dest_node,
           in_int_router, out_ready,
    output in_ready, out_valid, out_head, out_tail, route_op, route_orc, errors
  );

endinterface

// File: rtl/rtr_dor_next_hop.sv
// Dimension-order next hop: lowest mismatching dim picks its -/+ port, else eject.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: cur_addr/target_addr coords (dim0 in LSBs), rc phase index,
//        dest_node ejection node, op one-hot output port (0 if no legal port).
module rtr_dor_next_hop
  import rtr_route_gen_pkg::*;
(
  input  router_addr_t cur_addr,
  input  router_addr_t target_addr,
  input  rc_idx_t      rc,
  input  node_addr_t   dest_node,
  output port_oh_t     op
);

  logic found;

  always_comb begin
    op    = '0;
    found = 1'b0;
    for (int d = 0; d < num_dimensions; d++) begin
      if (!found &&
          (cur_addr[d*dim_addr_width +: dim_addr_width] !=
           target_addr[d*dim_addr_width +: dim_addr_width])) begin
        found = 1'b1;
        if (target_addr[d*dim_addr_width +: dim_addr_width] >
            cur_addr[d*dim_addr_width +: dim_addr_width])
          op[2*d + port_dir_inc] = 1'b1;
        else
          op[2*d + port_dir_dec] = 1'b1;
      end
    end
    // Ejection only in the final phase; an out-of-range node yields no port.
    if (!found && (rc == rc_last) && (int'(dest_node) < num_nodes_per_router))
      op[port_eject_base + int'(dest_node)] = 1'b1;
  end

endmodule

// File: rtl/rtr_route_gen.sv
// Per-VC route generator: computes port/class on head flits, reuses them for body/tail.
// Latency: 1 cycle from input accept to out_valid.
// Backpressure: in_ready = ~out_valid | out_ready; outputs held while stalled.
// Ports: clk, reset_n (async active-low), router_address (static own coords),
//        rg (slave side of rtr_route_gen_if: flit in, route out, errors).
module rtr_route_gen
  import rtr_route_gen_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  router_addr_t router_address,
  rtr_route_gen_if.slave rg
);

  route_gen_state_e state_q, state_d;
  route_t           route_held_q, route_held_d;
  route_t           out_route_q, out_route_d;
  logic             out_valid_q, out_valid_d;
  logic             out_head_q, out_head_d;
  logic             out_tail_q, out_tail_d;
  logic [1:0]       errors_q, errors_d;

  logic             accept;
  rc_idx_t          rc_in;
  rc_idx_t          rc_eff;
  router_addr_t     target;
  port_oh_t         hop_op;
  route_t           head_route;

  assign rg.in_ready = ~out_valid_q | rg.out_ready;
  assign accept      = rg.in_valid & rg.in_ready;

  // Phase advance: reaching the intermediate router moves the packet to the
  // next class, so the route never leaves {in_rc, in_rc+1}.
  always_comb begin
    rc_in  = rc_index(rg.in_rc);
    rc_eff = rc_in;
    if ((rc_in < rc_last) && (router_address == rg.in_int_router))
      rc_eff = rc_in + 1'b1;
    target = (rc_eff == '0) ? rg.in_int_router : rg.in_dest_router;
  end

  rtr_dor_next_hop u_next_hop (
    .cur_addr    (router_address),
    .target_addr (target),
    .rc          (rc_eff),
    .dest_node   (rg.in_dest_node),
    .op          (hop_op)
  );

  always_comb begin
    head_route.op          = hop_op;
    head_route.orc         = '0;
    head_route.orc[rc_eff] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    route_held_d = route_held_q;
    out_route_d  = out_route_q;
    out_valid_d  = out_valid_q;
    out_head_d   = out_head_q;
    out_tail_d   = out_tail_q;
    errors_d     = errors_q;

    // Drained with nothing behind it: drop valid and the flit's error flags.
    if (out_valid_q && rg.out_ready) begin
      out_valid_d = 1'b0;
      errors_d    = '0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_head_d  = rg.in_head;
      out_tail_d  = rg.in_tail;
      errors_d    = '0;
      if (rg.in_head) begin
        // A head while a packet is open abandons the old packet.
        errors_d[1]  = (state_q == ST_OPEN);
        out_route_d  = head_route;
        route_held_d = head_route;
        state_d      = rg.in_tail ? ST_IDLE : ST_OPEN;
      end else if (state_q == ST_OPEN) begin
        out_route_d = route_held_q;
        if (rg.in_tail) state_d = ST_IDLE;
      end else begin
        // Orphan body/tail: forwarded with no route so the allocator drops it.
        errors_d[0] = 1'b1;
        out_route_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      route_held_q <= '0;
      out_route_q  <= '0;
      out_valid_q  <= 1'b0;
      out_head_q   <= 1'b0;
      out_tail_q   <= 1'b0;
      errors_q     <= '0;
    end else begin
      state_q      <= state_d;
      route_held_q <= route_held_d;
      out_route_q  <= out_route_d;
      out_valid_q  <= out_valid_d;
      out_head_q   <= out_head_d;
      out_tail_q   <= out_tail_d;
      errors_q     <= errors_d;
    end
  end

  assign rg.out_valid = out_valid_q;
  assign rg.out_head  = out_head_q;
  assign rg.out_tail  = out_tail_q;
  assign rg.route_op  = out_route_q.op;
  assign rg.route_orc = out_route_q.orc;
  assign rg.errors    = errors_q;

endmodule

// File: tb/tb_rtr_route_gen.sv
// Directed bench for rtr_route_gen on a 4x4 mesh, router at (x1,y2).
// Ports: 0 x-, 1 x+, 2 y-, 3 y+, 4 eject.
module tb_rtr_route_gen;
  import rtr_route_gen_pkg::*;

  logic         clk;
  logic         reset_n;
  router_addr_t router_address;
  int           n_tests;
  int           n_fail;

  rtr_route_gen_if rg_if ();

  rtr_route_gen dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .router_address (router_address),
    .rg             (rg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic router_addr_t xy(input int x, input int y);
    logic [1:0] xs;
    logic [1:0] ys;
    xs = x[1:0];
    ys = y[1:0];
    return {ys, xs};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_route(input string tag, input logic h, input logic t,
                             input logic [4:0] eop, input logic [1:0] eorc,
                             input logic [1:0] eerr);
    check_eq({tag, "_vld"},  32'(rg_if.out_valid), 32'd1);
    check_eq({tag, "_head"}, 32'(rg_if.out_head),  32'(h));
    check_eq({tag, "_tail"}, 32'(rg_if.out_tail),  32'(t));
    check_eq({tag, "_op"},   32'(rg_if.route_op),  32'(eop));
    check_eq({tag, "_orc"},  32'(rg_if.route_orc), 32'(eorc));
    check_eq({tag, "_err"},  32'(rg_if.errors),    32'(eerr));
  endtask

  // Offer one flit, accept on the next edge, check the registered route.
  task automatic flit(input string tag, input logic h, input logic t,
                      input logic [1:0] rc, input router_addr_t dst,
                      input logic node, input router_addr_t intr,
                      input logic [4:0] eop, input logic [1:0] eorc,
                      input logic [1:0] eerr);
    @(negedge clk);
    rg_if.in_valid       = 1'b1;
    rg_if.in_head        = h;
    rg_if.in_tail        = t;
    rg_if.in_rc          = rc;
    rg_if.in_dest_router = dst;
    rg_if.in_dest_node   = node;
    rg_if.in_int_router  = intr;
    #1;
    check_eq({tag, "_in_rdy"}, 32'(rg_if.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rg_if.in_valid = 1'b0;
    check_route(tag, h, t, eop, eorc, eerr);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_vld"},  32'(rg_if.out_valid), 32'd0);
  endtask

  initial begin
    n_tests              = 0;
    n_fail               = 0;
    reset_n              = 1'b0;
    router_address       = xy(1, 2);
    rg_if.in_valid       = 1'b0;
    rg_if.in_head        = 1'b0;
    rg_if.in_tail        = 1'b0;
    rg_if.in_rc          = '0;
    rg_if.in_dest_router = '0;
    rg_if.in_dest_node   = '0;
    rg_if.in_int_router  = '0;
    rg_if.out_ready      = 1'b1;

    // Reset state
    #2;
    check_eq("rst_vld",  32'(rg_if.out_valid), 32'd0);
    check_eq("rst_head", 32'(rg_if.out_head),  32'd0);
    check_eq("rst_tail", 32'(rg_if.out_tail),  32'd0);
    check_eq("rst_op",   32'(rg_if.route_op),  32'd0);
    check_eq("rst_orc",  32'(rg_if.route_orc), 32'd0);
    check_eq("rst_err",  32'(rg_if.errors),    32'd0);
    check_eq("rst_rdy",  32'(rg_if.in_ready),  32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: rc0 toward intermediate (3,2): x+ in class 0
    flit("t1", 1, 1, 2'b01, xy(0, 0), 1'b0, xy(3, 2), 5'b00010, 2'b01, 2'b00);
    // 2: intermediate is here -> class 1 toward dest (1,0): y-
    flit("t2", 1, 1, 2'b01, xy(1, 0), 1'b0, xy(1, 2), 5'b00100, 2'b10, 2'b00);
    // 3: rc1 at destination -> eject; body/tail reuse it despite new dest fields
    flit("t3_h", 1, 0, 2'b10, xy(1, 2), 1'b0, xy(0, 0), 5'b10000, 2'b10, 2'b00);
    flit("t3_b1", 0, 0, 2'b01, xy(3, 3), 1'b0, xy(0, 0), 5'b10000, 2'b10, 2'b00);
    flit("t3_b2", 0, 0, 2'b01, xy(0, 0), 1'b0, xy(3, 3), 5'b10000, 2'b10, 2'b00);
    flit("t3_t", 0, 1, 2'b01, xy(3, 0), 1'b0, xy(0, 0), 5'b10000, 2'b10, 2'b00);
    // Packet closed: a fresh head raises no error. rc1 dest (1,1) -> y-
    flit("t3_nh", 1, 1, 2'b10, xy(1, 1), 1'b0, xy(0, 0), 5'b00100, 2'b10, 2'b00);
    @(posedge clk);
    #1;
    check_idle("t3_drain");

    // 4: backpressure, head rc1 dest (3,2) -> x+
    @(negedge clk);
    rg_if.out_ready      = 1'b0;
    rg_if.in_valid       = 1'b1;
    rg_if.in_head        = 1'b1;
    rg_if.in_tail        = 1'b0;
    rg_if.in_rc          = 2'b10;
    rg_if.in_dest_router = xy(3, 2);
    @(posedge clk);
    #1;
    check_route("t4_h", 1, 0, 5'b00010, 2'b10, 2'b00);
    rg_if.in_head        = 1'b0;
    rg_if.in_dest_router = xy(0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("t4_stall_rdy", 32'(rg_if.in_ready), 32'd0);
      check_route("t4_stall", 1, 0, 5'b00010, 2'b10, 2'b00);
    end
    @(negedge clk);
    rg_if.out_ready = 1'b1;
    #1;
    check_eq("t4_rel_rdy", 32'(rg_if.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check_route("t4_b", 0, 0, 5'b00010, 2'b10, 2'b00);
    rg_if.in_tail = 1'b1;
    @(posedge clk);
    #1;
    check_route("t4_t", 0, 1, 5'b00010, 2'b10, 2'b00);
    rg_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_idle("t4_drain");

    // 5: orphan body, then a head interrupting an open packet
    flit("t5_orph", 0, 0, 2'b10, xy(1, 2), 1'b0, xy(0, 0), 5'b00000, 2'b00, 2'b01);
    flit("t5_h", 1, 0, 2'b10, xy(1, 2), 1'b0, xy(0, 0), 5'b10000, 2'b10, 2'b00);
    flit("t5_h2", 1, 0, 2'b10, xy(0, 2), 1'b0, xy(0, 0), 5'b00001, 2'b10, 2'b10);
    flit("t5_t", 0, 1, 2'b10, xy(3, 3), 1'b0, xy(0, 0), 5'b00001, 2'b10, 2'b00);
    @(posedge clk);
    #1;
    check_idle("t5_drain");

    // 6: async reset mid-packet while the head is stalled at the output
    rg_if.out_ready = 1'b0;
    flit("t6_h", 1, 0, 2'b10, xy(1, 3), 1'b0, xy(0, 0), 5'b01000, 2'b10, 2'b00);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_vld",  32'(rg_if.out_valid), 32'd0);
    check_eq("t6_rst_head", 32'(rg_if.out_head),  32'd0);
    check_eq("t6_rst_op",   32'(rg_if.route_op),  32'd0);
    check_eq("t6_rst_orc",  32'(rg_if.route_orc), 32'd0);
    @(negedge clk);
    reset_n         = 1'b1;
    rg_if.out_ready = 1'b1;
    flit("t6_b", 0, 0, 2'b10, xy(1, 3), 1'b0, xy(0, 0), 5'b00000, 2'b00, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
